// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory loader.
// IMEM_LOADER_CHECKSUM_EN adds the CSUM state to the loader state encoding.
package imem_pkg;

    localparam logic [31:0] HALT_INSTR = 32'h0000007F;
    localparam int unsigned IMEM_DEPTH = 32;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RECV  = 3'd1,
        ST_WRITE = 3'd2,
        ST_DONE  = 3'd3
`ifdef IMEM_LOADER_CHECKSUM_EN
        ,
        ST_CSUM  = 3'd4
`endif
    } loader_state_t;

endpackage

// File: rtl/imem_loader.sv
// Byte-stream to instruction-RAM writer: packs 4 bytes little-endian per word, stops on halt or full RAM.
// Optional trailing checksum byte enabled by IMEM_LOADER_CHECKSUM_EN.
module imem_loader
    import imem_pkg::*;
#(
    parameter int unsigned DEPTH  = IMEM_DEPTH,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              busy,
    output logic              done,
    output logic              overflow,
`ifdef IMEM_LOADER_CHECKSUM_EN
    output logic              csum_err,
`endif
    output logic [ADDR_W:0]   word_count
);

    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

    loader_state_t     r_state;
    logic              r_in_ready;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [31:0]       r_wr_data;
    logic              r_busy;
    logic              r_done;
    logic              r_overflow;
    logic [ADDR_W:0]   r_word_count;
    logic [1:0]        r_byte_idx;
    logic              w_accept;
    logic [ADDR_W:0]   w_count_next;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        r_csum;
    logic              r_csum_err;
`endif

    assign w_accept     = in_valid && r_in_ready;
    assign w_count_next = r_word_count + (ADDR_W + 1)'(1);

    // Single-process FSM; every output is a register updated on the state transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_in_ready   <= 1'b0;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_overflow   <= 1'b0;
            r_word_count <= '0;
            r_byte_idx   <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_csum       <= '0;
            r_csum_err   <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_state      <= ST_RECV;
                        r_in_ready   <= 1'b1;
                        r_busy       <= 1'b1;
                        r_done       <= 1'b0;
                        r_overflow   <= 1'b0;
                        r_word_count <= '0;
                        r_byte_idx   <= '0;
                        r_wr_addr    <= '0;
                        r_wr_data    <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        r_csum       <= '0;
                        r_csum_err   <= 1'b0;
`endif
                    end
                end
                ST_RECV: begin
                    if (w_accept) begin
                        r_wr_data[{r_byte_idx, 3'b000} +: 8] <= in_data;
                        r_byte_idx <= r_byte_idx + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        r_csum     <= r_csum + in_data;
`endif
                        if (r_byte_idx == 2'd3) begin
                            r_state    <= ST_WRITE;
                            r_in_ready <= 1'b0;
                            r_wr_en    <= 1'b1;
                        end
                    end
                end
                ST_WRITE: begin
                    r_wr_en      <= 1'b0;
                    r_word_count <= w_count_next;
                    if (r_wr_data == HALT_INSTR) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        r_state    <= ST_CSUM;
                        r_in_ready <= 1'b1;
`else
                        r_state    <= ST_DONE;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
`endif
                    end else if (w_count_next == DEPTH_CNT) begin
                        // RAM full without a halt word: terminate, address never wraps.
                        r_state    <= ST_DONE;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                        r_overflow <= 1'b1;
                    end else begin
                        r_state    <= ST_RECV;
                        r_in_ready <= 1'b1;
                        r_wr_addr  <= r_wr_addr + ADDR_W'(1);
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                ST_CSUM: begin
                    if (w_accept) begin
                        r_csum_err <= (8'(r_csum + in_data) != 8'h00);
                        r_state    <= ST_DONE;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                    end
                end
`endif
                default: begin
                    r_state    <= ST_IDLE;
                    r_in_ready <= 1'b0;
                    r_wr_en    <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    assign wr_en      = r_wr_en;
    assign wr_addr    = r_wr_addr;
    assign wr_data    = r_wr_data;
    assign busy       = r_busy;
    assign done       = r_done;
    assign overflow   = r_overflow;
    assign word_count = r_word_count;
`ifdef IMEM_LOADER_CHECKSUM_EN
    assign csum_err   = r_csum_err;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: scoreboard of expected RAM writes vs. monitored writes.
// Covers the IMEM_LOADER_CHECKSUM_EN variant when the macro is defined.
module tb_imem_loader;
    import imem_pkg::*;

    localparam int unsigned ADDR_W = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic              busy;
    logic              done;
    logic              overflow;
    logic [ADDR_W:0]   word_count;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic              csum_err;
`endif

    imem_loader dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .done       (done),
        .overflow   (overflow),
`ifdef IMEM_LOADER_CHECKSUM_EN
        .csum_err   (csum_err),
`endif
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    // Monitor: records each write strobe and counts strobes lasting more than one cycle.
    logic [36:0] obs_arr [0:255];
    int          obs_wr  = 0;
    int          dbl_cnt = 0;
    logic        prev_wr = 1'b0;

    always @(negedge clk) begin
        if (wr_en && !rst) begin
            obs_arr[obs_wr[7:0]] <= {wr_addr, wr_data};
            obs_wr <= obs_wr + 1;
        end
        if (wr_en && prev_wr) dbl_cnt <= dbl_cnt + 1;
        prev_wr <= wr_en;
    end

    logic [36:0] exp_q [$];
    int          rd_ptr = 0;
    int          checks = 0;
    int          errors = 0;

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit ok;
        ok = 1'b0;
        repeat (gap) @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        for (int t = 0; t < 100; t++) begin
            if (in_ready) begin
                @(negedge clk);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_byte timeout: in_ready=%0b required 1", in_ready);
        end
    endtask

    task automatic send_word(input int addr, input logic [31:0] data, input int gap_max);
        exp_q.push_back({ADDR_W'(addr), data});
        for (int k = 0; k < 4; k++)
            send_byte(data[8*k +: 8], (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0);
    endtask

    task automatic load_normal(input int gap_max);
        send_word(0, 32'h00000033, gap_max);
        send_word(1, 32'h00600513, gap_max);
        send_word(2, 32'h0000007F, gap_max);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(8'hD6, 0);
`endif
    endtask

    task automatic wait_done();
        for (int t = 0; t < 500; t++) begin
            if (done) return;
            @(negedge clk);
        end
        checks++;
        errors++;
        $display("FAIL wait_done timeout: done=%0b required 1", done);
    endtask

    task automatic check_writes(input string name);
        logic [36:0] e;
        logic [36:0] o;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (rd_ptr >= obs_wr) begin
                errors++;
                $display("FAIL %s missing write: got none required addr=%0d data=%h", name, e[36:32], e[31:0]);
            end else begin
                o = obs_arr[rd_ptr[7:0]];
                rd_ptr++;
                if (o !== e) begin
                    errors++;
                    $display("FAIL %s write: got addr=%0d data=%h required addr=%0d data=%h",
                             name, o[36:32], o[31:0], e[36:32], e[31:0]);
                end
            end
        end
        checks++;
        if (obs_wr != rd_ptr) begin
            errors++;
            $display("FAIL %s extra writes: got %0d required 0", name, obs_wr - rd_ptr);
            rd_ptr = obs_wr;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (3) @(negedge clk);
        checks++;
        if ({in_ready, wr_en, busy, done, overflow} !== 5'b0) begin
            errors++;
            $display("FAIL reset flags: got %b required 00000", {in_ready, wr_en, busy, done, overflow});
        end
        checks++;
        if ({wr_addr, wr_data, word_count} !== '0) begin
            errors++;
            $display("FAIL reset values: got addr=%0d data=%h cnt=%0d required 0", wr_addr, wr_data, word_count);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_normal();
        do_start();
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL start_latency: got in_ready=%b busy=%b required 1 1", in_ready, busy);
        end
        send_word(0, 32'h00000033, 0);
        checks++;
        if (wr_en !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL write_cycle: got wr_en=%b in_ready=%b required 1 0", wr_en, in_ready);
        end
        @(negedge clk);
        checks++;
        if (wr_en !== 1'b0 || in_ready !== 1'b1 || word_count !== 6'd1) begin
            errors++;
            $display("FAIL after_write: got wr_en=%b in_ready=%b cnt=%0d required 0 1 1", wr_en, in_ready, word_count);
        end
        send_word(1, 32'h00600513, 0);
        send_word(2, 32'h0000007F, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(8'hD6, 0);
`endif
        wait_done();
        check_writes("normal");
        checks++;
        if (word_count !== 6'd3 || overflow !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL normal_end: got cnt=%0d ovf=%b busy=%b rdy=%b required 3 0 0 0",
                     word_count, overflow, busy, in_ready);
        end
    endtask

    task automatic test_backpressure();
        do_start();
        load_normal(5);
        wait_done();
        check_writes("backpressure");
        checks++;
        if (dbl_cnt !== 0) begin
            errors++;
            $display("FAIL wr_en_width: got %0d long strobes required 0", dbl_cnt);
        end
        checks++;
        if (word_count !== 6'd3 || done !== 1'b1) begin
            errors++;
            $display("FAIL backpressure_end: got cnt=%0d done=%b required 3 1", word_count, done);
        end
    endtask

    task automatic test_restart();
        do_start();
        checks++;
        if (done !== 1'b0 || word_count !== 6'd0 || wr_addr !== 5'd0) begin
            errors++;
            $display("FAIL restart_clear: got done=%b cnt=%0d addr=%0d required 0 0 0", done, word_count, wr_addr);
        end
        load_normal(1);
        wait_done();
        check_writes("restart");
    endtask

    task automatic test_overflow();
        do_start();
        for (int i = 0; i < 32; i++) send_word(i, 32'h00000033, 1);
        wait_done();
        check_writes("overflow");
        checks++;
        if (overflow !== 1'b1 || word_count !== 6'd32 || done !== 1'b1) begin
            errors++;
            $display("FAIL overflow_end: got ovf=%b cnt=%0d done=%b required 1 32 1", overflow, word_count, done);
        end
        in_valid = 1'b1;
        in_data  = 8'h33;
        repeat (10) @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (obs_wr != rd_ptr || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL overflow_stop: got extra=%0d rdy=%b required 0 0", obs_wr - rd_ptr, in_ready);
        end
    endtask

    task automatic test_reset_mid();
        do_start();
        send_word(0, 32'h00000033, 0);
        send_byte(8'h13, 0);
        send_byte(8'h05, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({in_ready, wr_en, busy, done, overflow} !== 5'b0 || word_count !== 6'd0 || wr_addr !== 5'd0) begin
            errors++;
            $display("FAIL reset_mid: got flags=%b cnt=%0d addr=%0d required 0 0 0",
                     {in_ready, wr_en, busy, done, overflow}, word_count, wr_addr);
        end
        check_writes("reset_mid_partial");
        do_start();
        load_normal(0);
        wait_done();
        check_writes("reset_mid_reload");
    endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        logic [7:0] cs [2];
        logic       exp_err [2];
        cs[0] = 8'hD6; exp_err[0] = 1'b0;
        cs[1] = 8'hD5; exp_err[1] = 1'b1;
        for (int r = 0; r < 2; r++) begin
            do_start();
            send_word(0, 32'h00000033, 2);
            send_word(1, 32'h00600513, 2);
            send_word(2, 32'h0000007F, 2);
            checks++;
            if (done !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL csum_wait: got done=%b busy=%b required 0 1", done, busy);
            end
            send_byte(cs[r], 1);
            wait_done();
            check_writes("checksum");
            checks++;
            if (csum_err !== exp_err[r] || done !== 1'b1) begin
                errors++;
                $display("FAIL csum_err: got err=%b done=%b required %b 1", csum_err, done, exp_err[r]);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_normal();
        test_backpressure();
        test_restart();
        test_overflow();
        test_reset_mid();
`ifdef IMEM_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
